// File: rtl/bf16_pkg.sv
// bf16_pkg: constants and types shared by the bf16 accumulator slice.
//   - Class flag bit indices (one-hot flag vectors from bf16_mul / bf16_acc)
//   - Exponent bias and canonical bf16 encodings
//   - FSM state encoding of the accumulator
package bf16_pkg;

  localparam int FLG_NAN  = 3;
  localparam int FLG_ZERO = 2;
  localparam int FLG_INF  = 1;
  localparam int FLG_NORM = 0;

  localparam int EXP_BIAS = 127;

  localparam logic [15:0] QNAN     = 16'h7FFF;
  localparam logic [15:0] INF_MAG  = 16'h7F80;
  localparam logic [15:0] ZERO_VAL = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_PACK = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bf16_acc_if.sv
// bf16_acc_if: control, term-input and result-output signals of bf16_acc.
//   i_start/i_len          start a reduction of i_len terms
//   i_valid/o_ready        term handshake, term = {i_data, i_flag}
//   o_valid/i_ready        result handshake, result = {o_data, o_flag}
//   o_busy                 accumulator is not idle
// Modports: slave = the accumulator, master = the producer/consumer side.
interface bf16_acc_if #(
  parameter int LEN_WIDTH  = 8,
  parameter int FLAG_WIDTH = 4
);
  logic                  i_start;
  logic [LEN_WIDTH-1:0]  i_len;
  logic                  i_valid;
  logic                  o_ready;
  logic [15:0]           i_data;
  logic [FLAG_WIDTH-1:0] i_flag;
  logic                  o_valid;
  logic                  i_ready;
  logic [15:0]           o_data;
  logic [FLAG_WIDTH-1:0] o_flag;
  logic                  o_busy;

  modport slave (
    input  i_start, i_len, i_valid, i_data, i_flag, i_ready,
    output o_ready, o_valid, o_data, o_flag, o_busy
  );

  modport master (
    output i_start, i_len, i_valid, i_data, i_flag, i_ready,
    input  o_ready, o_valid, o_data, o_flag, o_busy
  );
endinterface

// File: rtl/bf16_lzc.sv
// bf16_lzc: parametric leading-zero counter.
//   i_vec  in  WIDTH  vector to scan (MSB first)
//   o_cnt  out CNT_W  number of leading zeros; WIDTH when i_vec is all zero
module bf16_lzc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CNT_W-1:0] o_cnt
);

  // Ascending scan: the highest set bit is the last one to write o_cnt.
  always_comb begin
    o_cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) o_cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/bf16_acc.sv
// bf16_acc: sequential bf16 accumulator (reduction stage after bf16_mul).
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   bus (slave)      i_start/i_len, term handshake i_valid/o_ready with
//                    i_data/i_flag, result handshake o_valid/i_ready with
//                    o_data/o_flag, and o_busy
// Sums i_len terms into a sign / biased exponent / extended magnitude
// register, tracks sticky NaN/+Inf/-Inf, and emits one truncated bf16.
module bf16_acc
  import bf16_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int SIG_WIDTH  = 7,
  parameter int FLAG_WIDTH = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int GRD_WIDTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  bf16_acc_if.slave   bus
);

  localparam int MW = 1 + SIG_WIDTH + GRD_WIDTH;
  localparam int CW = $clog2(MW + 1);
  localparam int EW = EXP_WIDTH + 2;

  localparam logic [EXP_WIDTH-1:0] MW_E     = EXP_WIDTH'(MW);
  localparam logic signed [EW-1:0] EXP_OVF  = EW'(2 * EXP_BIAS + 1);
  localparam logic signed [EW-1:0] EXP_NONE = '0;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [MW-1:0]         mag_q, mag_d;
  logic                  nan_q, nan_d;
  logic                  pinf_q, pinf_d;
  logic                  ninf_q, ninf_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [15:0]           data_q, data_d;
  logic [FLAG_WIDTH-1:0] flag_q, flag_d;

  // Incoming term unpacked into accumulator format.
  logic                  t_sign;
  logic [EXP_WIDTH-1:0]  t_exp;
  logic [MW-1:0]         t_mag;

  assign t_sign = bus.i_data[15];
  assign t_exp  = bus.i_data[14 -: EXP_WIDTH];
  assign t_mag  = {1'b1, bus.i_data[SIG_WIDTH-1:0], GRD_WIDTH'(0)};

  // Aligned add datapath.
  logic                  acc_ge;
  logic [EXP_WIDTH-1:0]  diff;
  logic [EXP_WIDTH-1:0]  big_exp;
  logic [MW-1:0]         big_mag, sml_raw, sml_mag;
  logic                  big_sign, sml_sign;
  logic [MW:0]           sum;
  logic                  res_sign;
  logic [CW-1:0]         lz;
  logic [MW-1:0]         n_mag;
  logic signed [EW-1:0]  n_exp;

  bf16_lzc #(.WIDTH(MW), .CNT_W(CW)) u_lzc (
    .i_vec (sum[MW-1:0]),
    .o_cnt (lz)
  );

  always_comb begin
    acc_ge   = exp_q >= t_exp;
    diff     = acc_ge ? (exp_q - t_exp) : (t_exp - exp_q);
    big_exp  = acc_ge ? exp_q : t_exp;
    big_mag  = acc_ge ? mag_q : t_mag;
    big_sign = acc_ge ? sign_q : t_sign;
    sml_raw  = acc_ge ? t_mag : mag_q;
    sml_sign = acc_ge ? t_sign : sign_q;
    // Bits shifted below the guard field are discarded.
    sml_mag  = (diff >= MW_E) ? '0 : (sml_raw >> diff);

    // After alignment equal exponents may still leave the term larger,
    // so the subtraction direction follows the aligned magnitudes.
    if (big_sign == sml_sign) begin
      sum      = {1'b0, big_mag} + {1'b0, sml_mag};
      res_sign = big_sign;
    end else if (big_mag >= sml_mag) begin
      sum      = {1'b0, big_mag} - {1'b0, sml_mag};
      res_sign = big_sign;
    end else begin
      sum      = {1'b0, sml_mag} - {1'b0, big_mag};
      res_sign = sml_sign;
    end

    if (sum[MW]) begin
      n_mag = sum[MW:1];
      n_exp = EW'(big_exp) + EW'(1);
    end else begin
      n_mag = sum[MW-1:0] << lz;
      n_exp = EW'(big_exp) - EW'(lz);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mag_d   = mag_q;
    nan_d   = nan_q;
    pinf_d  = pinf_q;
    ninf_d  = ninf_q;
    valid_d = valid_q;
    data_d  = data_q;
    flag_d  = flag_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          cnt_d   = bus.i_len;
          sign_d  = 1'b0;
          exp_d   = '0;
          mag_d   = '0;
          nan_d   = 1'b0;
          pinf_d  = 1'b0;
          ninf_d  = 1'b0;
          state_d = (bus.i_len == '0) ? S_PACK : S_ACC;
        end
      end

      S_ACC: begin
        if (bus.i_valid && ready_q) begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (bus.i_flag[FLG_NAN]) begin
            nan_d = 1'b1;
          end else if (bus.i_flag[FLG_INF]) begin
            if (t_sign) ninf_d = 1'b1;
            else        pinf_d = 1'b1;
          end else if (bus.i_flag[FLG_ZERO]) begin
            // consumed, accumulator unchanged
          end else if (bus.i_flag[FLG_NORM]) begin
            if (sum == '0 || n_exp <= EXP_NONE) begin
              // exact cancellation or underflow: flush to +0
              sign_d = 1'b0;
              exp_d  = '0;
              mag_d  = '0;
            end else if (n_exp >= EXP_OVF) begin
              if (res_sign) ninf_d = 1'b1;
              else          pinf_d = 1'b1;
            end else begin
              sign_d = res_sign;
              exp_d  = n_exp[EXP_WIDTH-1:0];
              mag_d  = n_mag;
            end
          end
          if (cnt_q == LEN_WIDTH'(1)) state_d = S_PACK;
        end
      end

      S_PACK: begin
        if (nan_q || (pinf_q && ninf_q)) begin
          data_d = QNAN;
          flag_d = FLAG_WIDTH'(1) << FLG_NAN;
        end else if (pinf_q || ninf_q) begin
          data_d = {ninf_q, INF_MAG[14:0]};
          flag_d = FLAG_WIDTH'(1) << FLG_INF;
        end else if (mag_q == '0) begin
          data_d = ZERO_VAL;
          flag_d = FLAG_WIDTH'(1) << FLG_ZERO;
        end else begin
          // truncation toward zero: guard bits are dropped
          data_d = {sign_q, exp_q, mag_q[MW-2 -: SIG_WIDTH]};
          flag_d = FLAG_WIDTH'(1) << FLG_NORM;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        // First DONE cycle raises o_valid; result then holds until taken.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d == S_ACC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mag_q   <= '0;
      nan_q   <= 1'b0;
      pinf_q  <= 1'b0;
      ninf_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mag_q   <= mag_d;
      nan_q   <= nan_d;
      pinf_q  <= pinf_d;
      ninf_q  <= ninf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_flag  = flag_q;
  assign bus.o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_bf16_acc.sv
// tb_bf16_acc: directed and randomized bench for bf16_acc with an
// integer-sum reference model for the randomized reductions.
module tb_bf16_acc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bf16_acc_if bus ();

  bf16_acc dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  localparam logic [3:0] F_NAN  = 4'b1000;
  localparam logic [3:0] F_ZERO = 4'b0100;
  localparam logic [3:0] F_INF  = 4'b0010;
  localparam logic [3:0] F_NORM = 4'b0001;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] td[16];
  logic [3:0]  tf[16];

  // Exact integer -> bf16, truncating to 8 significant bits.
  function automatic logic [15:0] int_to_bf16(input int v);
    int m, e, mant;
    logic s;
    if (v == 0) return 16'h0000;
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    for (int b = 0; b < 31; b++) if (m >= (1 << b)) e = b;
    mant = (e >= 7) ? (m >> (e - 7)) : (m << (7 - e));
    return {s, 8'(127 + e), 7'(mant & 127)};
  endfunction

  task automatic idle_inputs();
    bus.i_start = 1'b0;
    bus.i_len   = '0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_flag  = '0;
    bus.i_ready = 1'b0;
  endtask

  task automatic start_red(input int len);
    bus.i_start = 1'b1;
    bus.i_len   = 8'(len);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic send_terms(input int n, input bit gap, output bit ok);
    int w;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = td[i];
      bus.i_flag  = tf[i];
      w = 0;
      while (!bus.o_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!bus.o_ready) ok = 1'b0;
      @(negedge clk);
      bus.i_valid = 1'b0;
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit ok);
    int w;
    w = 0;
    while (!bus.o_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = bus.o_valid;
  endtask

  task automatic reduce(input int n, input bit gap, output logic [15:0] d,
                        output logic [3:0] f, output bit ok);
    bit ok1, ok2;
    start_red(n);
    send_terms(n, gap, ok1);
    wait_valid(ok2);
    d  = bus.o_data;
    f  = bus.o_flag;
    ok = ok1 & ok2;
  endtask

  task automatic handshake();
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    obs = {bus.o_ready, bus.o_valid, bus.o_data, bus.o_flag, bus.o_busy};
    total_cnt++;
    if (obs !== 23'd0) $display("FAIL reset_outputs: got %h want 0", obs);
    else pass_cnt++;
  endtask

  task automatic test_add();
    logic [15:0] d; logic [3:0] f; bit ok;
    td[0] = 16'h3F80; tf[0] = F_NORM;
    td[1] = 16'h4000; tf[1] = F_NORM;
    reduce(2, 1'b0, d, f, ok);
    total_cnt++;
    if (!ok || d !== 16'h4040) $display("FAIL add_data: got %h ok=%0d want 4040", d, ok);
    else pass_cnt++;
    total_cnt++;
    if (f !== F_NORM) $display("FAIL add_flag: got %b want %b", f, F_NORM);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_cancel();
    logic [15:0] d; logic [3:0] f; bit ok;
    td[0] = 16'h3F80; tf[0] = F_NORM;
    td[1] = 16'hBF80; tf[1] = F_NORM;
    reduce(2, 1'b0, d, f, ok);
    total_cnt++;
    if (!ok || d !== 16'h0000) $display("FAIL cancel_data: got %h ok=%0d want 0000", d, ok);
    else pass_cnt++;
    total_cnt++;
    if (f !== F_ZERO) $display("FAIL cancel_flag: got %b want %b", f, F_ZERO);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_inf_nan();
    logic [15:0] d; logic [3:0] f; bit ok;
    td[0] = 16'h7F80; tf[0] = F_INF;
    td[1] = 16'h3F80; tf[1] = F_NORM;
    td[2] = 16'hFF80; tf[2] = F_INF;
    reduce(3, 1'b0, d, f, ok);
    total_cnt++;
    if (!ok || d !== 16'h7FFF) $display("FAIL infnan_data: got %h ok=%0d want 7fff", d, ok);
    else pass_cnt++;
    total_cnt++;
    if (f !== F_NAN) $display("FAIL infnan_flag: got %b want %b", f, F_NAN);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_overflow();
    logic [15:0] d; logic [3:0] f; bit ok;
    td[0] = 16'h7F00; tf[0] = F_NORM;
    td[1] = 16'h7F00; tf[1] = F_NORM;
    reduce(2, 1'b0, d, f, ok);
    total_cnt++;
    if (!ok || d !== 16'h7F80) $display("FAIL ovf_data: got %h ok=%0d want 7f80", d, ok);
    else pass_cnt++;
    total_cnt++;
    if (f !== F_INF) $display("FAIL ovf_flag: got %b want %b", f, F_INF);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_len_zero();
    start_red(0);
    @(negedge clk);
    total_cnt++;
    if (bus.o_valid !== 1'b0) $display("FAIL len0_early_valid: got %b want 0", bus.o_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.o_valid !== 1'b1) $display("FAIL len0_valid: got %b want 1", bus.o_valid);
    else pass_cnt++;
    total_cnt++;
    if ({bus.o_data, bus.o_flag} !== {16'h0000, F_ZERO})
      $display("FAIL len0_result: got %h/%b want 0000/%b", bus.o_data, bus.o_flag, F_ZERO);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_start_ignored();
    logic [15:0] d; logic [3:0] f; bit ok;
    td[0] = 16'h3F80; tf[0] = F_NORM;
    td[1] = 16'h3F80; tf[1] = F_NORM;
    reduce(2, 1'b0, d, f, ok);
    total_cnt++;
    if (!ok || d !== 16'h4000) $display("FAIL two_data: got %h ok=%0d want 4000", d, ok);
    else pass_cnt++;
    bus.i_ready = 1'b1;
    bus.i_start = 1'b1;
    bus.i_len   = 8'd1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_start = 1'b0;
    total_cnt++;
    if ({bus.o_busy, bus.o_valid} !== 2'b00)
      $display("FAIL start_in_done: busy/valid got %b want 00", {bus.o_busy, bus.o_valid});
    else pass_cnt++;
  endtask

  task automatic test_gapped_hold_reset();
    logic [15:0] d; logic [3:0] f; bit ok;
    bit ok1;
    logic [22:0] obs;
    for (int i = 0; i < 4; i++) begin
      td[i] = 16'h3F80;
      tf[i] = F_NORM;
    end
    reduce(4, 1'b1, d, f, ok);
    total_cnt++;
    if (!ok || d !== 16'h4080) $display("FAIL gap_data: got %h ok=%0d want 4080", d, ok);
    else pass_cnt++;
    total_cnt++;
    if (f !== F_NORM) $display("FAIL gap_flag: got %b want %b", f, F_NORM);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if ({bus.o_valid, bus.o_data} !== {1'b1, 16'h4080})
        $display("FAIL hold_c%0d: got valid=%b data=%h want 1/4080", c, bus.o_valid, bus.o_data);
      else pass_cnt++;
    end
    handshake();
    total_cnt++;
    if (bus.o_valid !== 1'b0) $display("FAIL valid_after_hs: got %b want 0", bus.o_valid);
    else pass_cnt++;

    td[0] = 16'h3F80; tf[0] = F_NORM;
    start_red(4);
    send_terms(1, 1'b0, ok1);
    total_cnt++;
    if (!ok1 || {bus.o_ready, bus.o_busy} !== 2'b11)
      $display("FAIL mid_acc: ready/busy got %b want 11", {bus.o_ready, bus.o_busy});
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    obs = {bus.o_ready, bus.o_valid, bus.o_data, bus.o_flag, bus.o_busy};
    total_cnt++;
    if (obs !== 23'd0) $display("FAIL mid_reset: got %h want 0", obs);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] d; logic [3:0] f; bit ok;
    logic [15:0] exp_d; logic [3:0] exp_f;
    int n, sum, v, r;
    bit nan, pinf, ninf, s;
    for (int run = 0; run < 12; run++) begin
      n = $urandom_range(1, 8);
      sum = 0; nan = 0; pinf = 0; ninf = 0;
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 47);
        if (r == 0) begin
          td[i] = 16'h7FC0; tf[i] = F_NAN; nan = 1;
        end else if (r <= 2) begin
          s = 1'($urandom_range(0, 1));
          td[i] = s ? 16'hFF80 : 16'h7F80; tf[i] = F_INF;
          if (s) ninf = 1; else pinf = 1;
        end else if (r <= 6) begin
          td[i] = $urandom_range(0, 1) ? 16'h8000 : 16'h0000; tf[i] = F_ZERO;
        end else begin
          v = $urandom_range(1, 127);
          if ($urandom_range(0, 1) == 1) v = -v;
          td[i] = int_to_bf16(v); tf[i] = F_NORM;
          sum += v;
        end
      end
      if (nan || (pinf && ninf)) begin
        exp_d = 16'h7FFF; exp_f = F_NAN;
      end else if (pinf) begin
        exp_d = 16'h7F80; exp_f = F_INF;
      end else if (ninf) begin
        exp_d = 16'hFF80; exp_f = F_INF;
      end else if (sum == 0) begin
        exp_d = 16'h0000; exp_f = F_ZERO;
      end else begin
        exp_d = int_to_bf16(sum); exp_f = F_NORM;
      end
      reduce(n, run[0], d, f, ok);
      total_cnt++;
      if (!ok || d !== exp_d)
        $display("FAIL rand%0d_data: n=%0d sum=%0d got %h ok=%0d want %h", run, n, sum, d, ok, exp_d);
      else pass_cnt++;
      total_cnt++;
      if (f !== exp_f) $display("FAIL rand%0d_flag: got %b want %b", run, f, exp_f);
      else pass_cnt++;
      handshake();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_cancel();
    test_inf_nan();
    test_overflow();
    test_len_zero();
    test_start_ignored();
    test_gapped_hold_reset();
    test_add();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
